// File: rtl/pkt_pkg.sv
// Shared types and defaults for the packet framer: FSM state encoding and
// the sync/length limits used by the controller and its bench.
package pkt_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_LEN,
    S_PAY,
    S_CSUM
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         MAX_LEN_DEF   = 255;

  function automatic logic len_ok(input logic [7:0] len, input int max_len);
    return (len != 8'd0) && (int'(len) <= max_len);
  endfunction

endpackage

// File: rtl/pkt_framer_ctrl_if.sv
// FIFO read port plus outgoing framed byte stream, seen from the framer
// (master) and from the FIFO/serializer environment (slave).
interface pkt_framer_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_empty;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_sop;
  logic                  m_eop;

  modport master (
    output fifo_rd_en, m_valid, m_data, m_sop, m_eop,
    input  fifo_data, fifo_empty, m_ready
  );

  modport slave (
    input  fifo_rd_en, m_valid, m_data, m_sop, m_eop,
    output fifo_data, fifo_empty, m_ready
  );
endinterface

// File: rtl/pkt_prefetch_buf.sv
// Two-entry payload buffer behind a 1-cycle-latency FIFO read port; tracks the
// read in flight so the buffer can never be overrun.
module pkt_prefetch_buf
  import pkt_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  can_read,
  output logic                  push,
  output logic [DATA_WIDTH-1:0] head,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] ent0, ent1;
  logic                  wr_ptr, rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      push   <= 1'b0;
      ent0   <= '0;
      ent1   <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      push <= rd_en;
      if (push) begin
        if (wr_ptr) ent1 <= fifo_data;
        else        ent0 <= fifo_data;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = rd_ptr ? ent1 : ent0;
  // push doubles as the in-flight flag: its data is not yet counted
  assign can_read = ({1'b0, count} + {2'b00, push} - {2'b00, pop}) < 3'd2;

endmodule

// File: rtl/pkt_framer_ctrl.sv
// Frames FIFO payload into sync / length / payload / XOR-checksum packets on a
// valid/ready byte stream, prefetching payload through a 2-entry buffer.
module pkt_framer_ctrl
  import pkt_pkg::*;
#(
  parameter int         DATA_WIDTH = 8,
  parameter int         MAX_LEN    = MAX_LEN_DEF,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         cfg_len,
  pkt_framer_ctrl_if.master  bus,
  output logic               busy,
  output logic               done,
  output logic               len_err
);

  state_t                state, state_nxt;
  logic [7:0]            len_q, rem, issued;
  logic [DATA_WIDTH-1:0] csum;
  logic                  hs, pop, start_ok;
  logic                  can_read, push;
  logic [DATA_WIDTH-1:0] head;
  logic [1:0]            count;

  assign hs       = bus.m_valid && bus.m_ready;
  assign pop      = (state == S_PAY) && hs;
  assign start_ok = (state == S_IDLE) && start && len_ok(cfg_len, MAX_LEN);

  assign bus.fifo_rd_en = (state == S_SYNC || state == S_LEN || state == S_PAY) &&
                          !bus.fifo_empty && (issued < len_q) && can_read;

  pkt_prefetch_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (bus.fifo_rd_en),
    .pop      (pop),
    .fifo_data(bus.fifo_data),
    .can_read (can_read),
    .push     (push),
    .head     (head),
    .count    (count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (start_ok)             state_nxt = S_SYNC;
      S_SYNC: if (hs)                   state_nxt = S_LEN;
      S_LEN:  if (hs)                   state_nxt = S_PAY;
      S_PAY:  if (pop && rem == 8'd1)   state_nxt = S_CSUM;
      S_CSUM: if (hs)                   state_nxt = S_IDLE;
      default:                          state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.m_valid = 1'b0;
    bus.m_data  = '0;
    bus.m_sop   = 1'b0;
    bus.m_eop   = 1'b0;
    busy        = (state != S_IDLE);
    unique case (state)
      S_SYNC: begin bus.m_valid = 1'b1; bus.m_data = SYNC_BYTE; bus.m_sop = 1'b1; end
      S_LEN:  begin bus.m_valid = 1'b1; bus.m_data = len_q; end
      S_PAY:  begin bus.m_valid = (count != 2'd0); bus.m_data = head; end
      S_CSUM: begin bus.m_valid = 1'b1; bus.m_data = csum; bus.m_eop = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q   <= 8'd0;
      rem     <= 8'd0;
      issued  <= 8'd0;
      csum    <= '0;
      done    <= 1'b0;
      len_err <= 1'b0;
    end else begin
      done    <= (state == S_CSUM) && hs;
      len_err <= (state == S_IDLE) && start && !len_ok(cfg_len, MAX_LEN);
      if (start_ok) begin
        len_q  <= cfg_len;
        rem    <= cfg_len;
        issued <= 8'd0;
        csum   <= '0;
      end else begin
        if (bus.fifo_rd_en) issued <= issued + 8'd1;
        if (pop) begin
          rem  <= rem - 8'd1;
          csum <= csum ^ head;
        end
      end
    end
  end

endmodule
